// File: rtl/eq_serial_ctrl_amisha_if.sv
// Request/operand/result bundle of the bit-serial equality controller,
// including the bit lanes to and from the shared 1-bit equality cell.
interface eq_serial_ctrl_amisha_if #(
    parameter int WIDTH = 8
);
    logic             req0_amisha;
    logic [WIDTH-1:0] a0_amisha;
    logic [WIDTH-1:0] b0_amisha;
    logic             req1_amisha;
    logic [WIDTH-1:0] a1_amisha;
    logic [WIDTH-1:0] b1_amisha;
    logic             ack0_amisha;
    logic             ack1_amisha;
    logic             eq_out_amisha;
    logic             busy_amisha;
    logic             cmp_a_amisha;
    logic             cmp_b_amisha;
    logic             cmp_eq_amisha;

    modport slave (
        input  req0_amisha, a0_amisha, b0_amisha,
        input  req1_amisha, a1_amisha, b1_amisha,
        input  cmp_eq_amisha,
        output ack0_amisha, ack1_amisha, eq_out_amisha, busy_amisha,
        output cmp_a_amisha, cmp_b_amisha
    );

    modport master (
        output req0_amisha, a0_amisha, b0_amisha,
        output req1_amisha, a1_amisha, b1_amisha,
        output cmp_eq_amisha,
        input  ack0_amisha, ack1_amisha, eq_out_amisha, busy_amisha,
        input  cmp_a_amisha, cmp_b_amisha
    );
endinterface

// File: rtl/eq_serial_ctrl_amisha.sv
// Round-robin bit-serial word-equality controller sharing one external 1-bit eq cell.
// Define EARLY_EXIT_EN to finish a compare on the first mismatching bit.
module eq_serial_ctrl_amisha #(
    parameter int WIDTH = 8
) (
    input  logic                    clk_amisha,
    input  logic                    rst_n_amisha,
    eq_serial_ctrl_amisha_if.slave  bus
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              acc_q, acc_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              eq_q, eq_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic              grant1;

    // On a tie the requester that was not served last wins.
    assign grant1 = bus.req1_amisha & (~bus.req0_amisha | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        eq_d         = eq_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_amisha || bus.req1_amisha) begin
                    owner_d = grant1;
                    a_sh_d  = grant1 ? bus.a1_amisha : bus.a0_amisha;
                    b_sh_d  = grant1 ? bus.b1_amisha : bus.b0_amisha;
                    idx_d   = '0;
                    acc_d   = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                acc_d  = acc_q & bus.cmp_eq_amisha;
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                if (idx_q == IDXW'(WIDTH - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
`ifdef EARLY_EXIT_EN
                if (!bus.cmp_eq_amisha) begin
                    acc_d   = 1'b0;
                    idx_d   = '0;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                eq_d         = acc_q;
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= 1'b1;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            eq_q         <= 1'b0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            eq_q         <= eq_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
        end
    end

    // The LSB of each shift register is the bit currently presented to the cell.
    assign bus.cmp_a_amisha  = (state_q == CMP) & a_sh_q[0];
    assign bus.cmp_b_amisha  = (state_q == CMP) & b_sh_q[0];
    assign bus.busy_amisha   = (state_q != IDLE);
    assign bus.ack0_amisha   = (state_q == DONE) & ~owner_q;
    assign bus.ack1_amisha   = (state_q == DONE) &  owner_q;
    assign bus.eq_out_amisha = (state_q == DONE) ? acc_q : eq_q;
endmodule

// File: tb/tb_eq_serial_ctrl_amisha.sv
// Self-checking bench for eq_serial_ctrl_amisha: directed scenarios plus
// randomized transactions against a word-level reference model.
module tb_eq_serial_ctrl_amisha;
    localparam int W = 8;
`ifdef EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    eq_serial_ctrl_amisha_if #(.WIDTH(W)) bus();

    eq_serial_ctrl_amisha #(.WIDTH(W)) dut (
        .clk_amisha   (clk),
        .rst_n_amisha (rst_n),
        .bus          (bus)
    );

    // Behavioural stand-in for the shared gate-level 1-bit equality cell.
    assign bus.cmp_eq_amisha = ~(bus.cmp_a_amisha ^ bus.cmp_b_amisha);

    always #5 clk = ~clk;

    // Edges from capture to the edge that samples ack.
    function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        int k_first = W;
        for (int k = W - 1; k >= 0; k--)
            if (a[k] != b[k]) k_first = k;
        if (EARLY && k_first < W) return k_first + 2;
        return W + 1;
    endfunction

    function automatic logic [5:0] out_vec();
        return {bus.busy_amisha, bus.ack0_amisha, bus.ack1_amisha,
                bus.eq_out_amisha, bus.cmp_a_amisha, bus.cmp_b_amisha};
    endfunction

    // Runs one transaction; entered shortly after a rising edge with the DUT idle.
    // lat = 0 means no ack arrived within the cycle budget.
    task automatic do_txn(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int chg_at, input logic [W-1:0] chg_val,
                          output int lat, output logic eqv, output logic other_ack,
                          output logic [W-1:0] seq);
        lat = 0; eqv = 1'bx; other_ack = 1'b0; seq = '0;
        if (!who) begin
            bus.req0_amisha = 1'b1; bus.a0_amisha = a; bus.b0_amisha = b;
        end else begin
            bus.req1_amisha = 1'b1; bus.a1_amisha = a; bus.b1_amisha = b;
        end
        @(posedge clk);
        for (int n = 1; n <= 4 * W; n++) begin
            @(negedge clk);
            if (n == chg_at) begin
                if (!who) bus.a0_amisha = chg_val;
                else      bus.a1_amisha = chg_val;
            end
            if (n <= W) seq[n-1] = bus.cmp_a_amisha;
            if ((who ? bus.ack0_amisha : bus.ack1_amisha) == 1'b1) other_ack = 1'b1;
            if ((who ? bus.ack1_amisha : bus.ack0_amisha) == 1'b1) begin
                lat = n;
                eqv = bus.eq_out_amisha;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!who) bus.req0_amisha = 1'b0;
        else      bus.req1_amisha = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (out_vec() !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b", out_vec(), 6'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_vec() !== 6'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: got %b expected %b", out_vec(), 6'b0);
        end
    endtask

    task automatic test_equal_a5();
        int lat; logic eqv, oth; logic [W-1:0] seq;
        @(posedge clk); #1;
        do_txn(1'b0, 8'hA5, 8'hA5, 0, '0, lat, eqv, oth, seq);
        vectors++;
        if (seq !== 8'hA5) begin
            miscompares++; $display("FAIL a5_cmp_a_seq: got %h expected %h", seq, 8'hA5);
        end
        vectors++;
        if (lat !== W + 1) begin
            miscompares++; $display("FAIL a5_latency: got %0d expected %0d", lat, W + 1);
        end
        vectors++;
        if (eqv !== 1'b1) begin
            miscompares++; $display("FAIL a5_eq: got %b expected 1", eqv);
        end
        vectors++;
        if (oth !== 1'b0) begin
            miscompares++; $display("FAIL a5_ack1_quiet: got %b expected 0", oth);
        end
        @(negedge clk);
        vectors++;
        if ({bus.busy_amisha, bus.ack0_amisha, bus.ack1_amisha} !== 3'b000) begin
            miscompares++;
            $display("FAIL a5_ack_width: got %b expected 000",
                     {bus.busy_amisha, bus.ack0_amisha, bus.ack1_amisha});
        end
    endtask

    task automatic test_msb_diff();
        int lat; logic eqv, oth; logic [W-1:0] seq;
        @(posedge clk); #1;
        do_txn(1'b0, 8'hA5, 8'h25, 0, '0, lat, eqv, oth, seq);
        vectors++;
        if (lat !== W + 1) begin
            miscompares++; $display("FAIL msb_latency: got %0d expected %0d", lat, W + 1);
        end
        vectors++;
        if (eqv !== 1'b0) begin
            miscompares++; $display("FAIL msb_eq: got %b expected 0", eqv);
        end
    endtask

    task automatic test_lsb_diff_req1();
        int lat; logic eqv, oth; logic [W-1:0] seq;
        @(posedge clk); #1;
        do_txn(1'b1, 8'h01, 8'h00, 0, '0, lat, eqv, oth, seq);
        vectors++;
        if (lat !== (EARLY ? 2 : W + 1)) begin
            miscompares++;
            $display("FAIL lsb_latency: got %0d expected %0d", lat, EARLY ? 2 : W + 1);
        end
        vectors++;
        if (eqv !== 1'b0) begin
            miscompares++; $display("FAIL lsb_eq: got %b expected 0", eqv);
        end
        vectors++;
        if (oth !== 1'b0) begin
            miscompares++; $display("FAIL lsb_ack0_quiet: got %b expected 0", oth);
        end
    endtask

    task automatic test_operand_change();
        int lat; logic eqv, oth; logic [W-1:0] seq;
        @(posedge clk); #1;
        do_txn(1'b0, 8'h3C, 8'h3C, 2, 8'hFF, lat, eqv, oth, seq);
        vectors++;
        if (eqv !== 1'b1) begin
            miscompares++; $display("FAIL captured_operands_eq: got %b expected 1", eqv);
        end
        vectors++;
        if (lat !== W + 1) begin
            miscompares++; $display("FAIL captured_operands_lat: got %0d expected %0d", lat, W + 1);
        end
    endtask

    task automatic test_reset_mid();
        int lat, stray; logic eqv, oth; logic [W-1:0] seq;
        @(posedge clk); #1;
        bus.req0_amisha = 1'b1; bus.a0_amisha = 8'h5A; bus.b0_amisha = 8'h5A;
        @(posedge clk);
        repeat (5) @(negedge clk);
        vectors++;
        if (bus.busy_amisha !== 1'b1) begin
            miscompares++; $display("FAIL midreset_busy_before: got %b expected 1", bus.busy_amisha);
        end
        rst_n = 1'b0;
        bus.req0_amisha = 1'b0;
        #1;
        vectors++;
        if (out_vec() !== 6'b0) begin
            miscompares++; $display("FAIL midreset_outputs: got %b expected %b", out_vec(), 6'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (bus.ack0_amisha || bus.ack1_amisha || bus.busy_amisha) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++; $display("FAIL midreset_dropped: got %0d active cycles expected 0", stray);
        end
        @(posedge clk); #1;
        do_txn(1'b0, 8'h5A, 8'h5A, 0, '0, lat, eqv, oth, seq);
        vectors++;
        if (lat !== W + 1 || eqv !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_rereq: got lat=%0d eq=%b expected lat=%0d eq=1", lat, eqv, W + 1);
        end
    endtask

    task automatic test_alternate();
        int order[$], when[$], eqs[$];
        int wide, n;
        logic prev;
        logic [W-1:0] op_a[2], op_b[2];
        op_a[0] = 8'h11; op_b[0] = 8'h11;
        op_a[1] = 8'h22; op_b[1] = 8'h23;
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0_amisha = 1'b1; bus.a0_amisha = op_a[0]; bus.b0_amisha = op_b[0];
        bus.req1_amisha = 1'b1; bus.a1_amisha = op_a[1]; bus.b1_amisha = op_b[1];
        @(negedge clk);
        rst_n = 1'b1;
        wide = 0; prev = 1'b0; n = 0;
        while (n < 8 * (W + 2) && order.size() < 4) begin
            @(negedge clk);
            n++;
            if (bus.ack0_amisha || bus.ack1_amisha) begin
                if (prev) wide++;
                order.push_back(bus.ack1_amisha ? 1 : 0);
                when.push_back(n);
                eqs.push_back(int'(bus.eq_out_amisha));
                if (order.size() == 4) begin
                    bus.req0_amisha = 1'b0; bus.req1_amisha = 1'b0;
                end
            end
            prev = bus.ack0_amisha | bus.ack1_amisha;
        end
        vectors++;
        if (order.size() !== 4) begin
            miscompares++; $display("FAIL alt_ack_count: got %0d expected 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (order[i] !== (i % 2)) begin
                    miscompares++; $display("FAIL alt_grant_%0d: got %0d expected %0d", i, order[i], i % 2);
                end
                vectors++;
                if (eqs[i] !== int'(op_a[i%2] == op_b[i%2])) begin
                    miscompares++;
                    $display("FAIL alt_eq_%0d: got %0d expected %0d", i, eqs[i], int'(op_a[i%2] == op_b[i%2]));
                end
                if (i > 0) begin
                    vectors++;
                    if (when[i] - when[i-1] !== 1 + exp_latency(op_a[i%2], op_b[i%2])) begin
                        miscompares++;
                        $display("FAIL alt_gap_%0d: got %0d expected %0d", i, when[i] - when[i-1],
                                 1 + exp_latency(op_a[i%2], op_b[i%2]));
                    end
                end
            end
        end
        vectors++;
        if (wide !== 0) begin
            miscompares++; $display("FAIL alt_ack_width: got %0d wide acks expected 0", wide);
        end
        repeat (2 * W + 4) @(negedge clk);
        vectors++;
        if (bus.busy_amisha !== 1'b0) begin
            miscompares++; $display("FAIL alt_settle_idle: got %b expected 0", bus.busy_amisha);
        end
    endtask

    task automatic test_random();
        int lat; logic eqv, oth; logic [W-1:0] seq, a, b;
        bit who;
        for (int t = 0; t < 40; t++) begin
            who = 1'($urandom_range(0, 1));
            a   = W'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: b = W'($urandom);
            endcase
            @(posedge clk); #1;
            do_txn(who, a, b, 0, '0, lat, eqv, oth, seq);
            vectors++;
            if (eqv !== (a == b)) begin
                miscompares++;
                $display("FAIL rand_eq t=%0d a=%h b=%h: got %b expected %b", t, a, b, eqv, a == b);
            end
            vectors++;
            if (lat !== exp_latency(a, b)) begin
                miscompares++;
                $display("FAIL rand_lat t=%0d a=%h b=%h: got %0d expected %0d", t, a, b, lat, exp_latency(a, b));
            end
            vectors++;
            if (oth !== 1'b0) begin
                miscompares++; $display("FAIL rand_other_ack t=%0d: got %b expected 0", t, oth);
            end
        end
    endtask

    initial begin
        bus.req0_amisha = 1'b0; bus.a0_amisha = '0; bus.b0_amisha = '0;
        bus.req1_amisha = 1'b0; bus.a1_amisha = '0; bus.b1_amisha = '0;
        test_reset();
        test_equal_a5();
        test_msb_diff();
        test_lsb_diff_req1();
        test_operand_change();
        test_reset_mid();
        test_alternate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
